mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates an instruction-fetch port (I) and a data port (D) onto one
//   single-ported word memory with a one-cycle registered read.
//
//   Handshake: a request transfers in a cycle where valid & ready are both
//   high. Ready is a combinational function of both valids and the
//   round-robin state, so at most one ready is high per cycle. A requester
//   that sees ready low keeps valid and its payload stable until ready is
//   high. Every accepted request produces exactly one response pulse
//   (rsp_valid) on the same port one cycle later. Responses cannot be
//   stalled.
//
//   Ports
//     clk, rst_n       clock, synchronous active-low reset
//     i_valid/i_addr   fetch request, byte address
//     i_ready          fetch request accepted this cycle
//     i_rsp_*          fetch response (valid, data, err)
//     d_valid/d_we/d_be/d_addr/d_wdata   data request
//     d_ready          data request accepted this cycle
//     d_rsp_*          data response (valid, data, err)
//     mem_en/we/be/addr/wdata   memory access, driven in the grant cycle
//     mem_rdata        memory read data, one cycle after a read strobe
module mem_arbiter #(
   parameter int WORDS = 64
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_valid,
   input  logic [31:0]                  i_addr,
   output logic                         i_ready,
   output logic                         i_rsp_valid,
   output logic [31:0]                  i_rsp_data,
   output logic                         i_rsp_err,
   input  logic                         d_valid,
   input  logic                         d_we,
   input  logic [3:0]                   d_be,
   input  logic [31:0]                  d_addr,
   input  logic [31:0]                  d_wdata,
   output logic                         d_ready,
   output logic                         d_rsp_valid,
   output logic [31:0]                  d_rsp_data,
   output logic                         d_rsp_err,
   output logic                         mem_en,
   output logic                         mem_we,
   output logic [3:0]                   mem_be,
   output logic [$clog2(WORDS)-1:0]     mem_addr,
   output logic [31:0]                  mem_wdata,
   input  logic [31:0]                  mem_rdata
);

   localparam int IDX_W = $clog2(WORDS);

   // Owner of the response presented in the current cycle.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   owner_t      owner_q;
   owner_t      owner_d;
   logic        last_d_q;   // 1: D was granted last, so I wins the next conflict
   logic        err_q;      // pending response carries an error
   logic        rd_q;       // pending response returns memory read data

   logic        grant_i;
   logic        grant_d;
   logic        any_grant;
   logic [31:0] sel_addr;
   logic        sel_err;
   logic        sel_rd;

   // Grant decode. Gated by rst_n so nothing is accepted while in reset.
   always_comb begin
      grant_i   = rst_n && i_valid && (!d_valid || last_d_q);
      grant_d   = rst_n && d_valid && (!i_valid || !last_d_q);
      any_grant = grant_i || grant_d;
      sel_addr  = grant_d ? d_addr : i_addr;
      // Misaligned or beyond the last word: accepted, but never reaches memory.
      sel_err   = (sel_addr[1:0] != 2'b00) ||
                  ({2'b00, sel_addr[31:2]} >= 32'(WORDS));
      sel_rd    = grant_i || (grant_d && !d_we);

      owner_d = OWN_NONE;
      if (grant_i) begin
         owner_d = OWN_I;
      end else if (grant_d) begin
         owner_d = OWN_D;
      end
   end

   // Memory strobe and payload, combinational in the grant cycle.
   always_comb begin
      i_ready   = grant_i;
      d_ready   = grant_d;
      mem_en    = any_grant && !sel_err;
      mem_we    = mem_en && grant_d && d_we;
      mem_be    = (mem_en && grant_d) ? d_be : 4'h0;
      mem_addr  = mem_en ? sel_addr[IDX_W+1:2] : '0;
      mem_wdata = (mem_en && grant_d) ? d_wdata : 32'h0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         owner_q  <= OWN_NONE;
         last_d_q <= 1'b1;
         err_q    <= 1'b0;
         rd_q     <= 1'b0;
      end else begin
         owner_q <= owner_d;
         err_q   <= any_grant && sel_err;
         rd_q    <= any_grant && sel_rd && !sel_err;
         if (any_grant) begin
            last_d_q <= grant_d;
         end
      end
   end

   // Response outputs. The idle port always shows zeros; reset blanks both.
   always_comb begin
      i_rsp_valid = rst_n && (owner_q == OWN_I);
      d_rsp_valid = rst_n && (owner_q == OWN_D);
      i_rsp_err   = i_rsp_valid && err_q;
      d_rsp_err   = d_rsp_valid && err_q;
      i_rsp_data  = (i_rsp_valid && rd_q) ? mem_rdata : 32'h0;
      d_rsp_data  = (d_rsp_valid && rd_q) ? mem_rdata : 32'h0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter with hand-computed expectations.
//   Inputs change just after the falling edge; outputs are checked 1 ns later,
//   well away from the rising edge.
module tb_mem_arbiter;

   localparam int WORDS = 64;
   localparam int IDX_W = $clog2(WORDS);

   logic              clk;
   logic              rst_n;
   logic              i_valid;
   logic [31:0]       i_addr;
   logic              i_ready;
   logic              i_rsp_valid;
   logic [31:0]       i_rsp_data;
   logic              i_rsp_err;
   logic              d_valid;
   logic              d_we;
   logic [3:0]        d_be;
   logic [31:0]       d_addr;
   logic [31:0]       d_wdata;
   logic              d_ready;
   logic              d_rsp_valid;
   logic [31:0]       d_rsp_data;
   logic              d_rsp_err;
   logic              mem_en;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [IDX_W-1:0]  mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   int vec_cnt;
   int err_cnt;

   mem_arbiter #(.WORDS(WORDS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_valid     (i_valid),
      .i_addr      (i_addr),
      .i_ready     (i_ready),
      .i_rsp_valid (i_rsp_valid),
      .i_rsp_data  (i_rsp_data),
      .i_rsp_err   (i_rsp_err),
      .d_valid     (d_valid),
      .d_we        (d_we),
      .d_be        (d_be),
      .d_addr      (d_addr),
      .d_wdata     (d_wdata),
      .d_ready     (d_ready),
      .d_rsp_valid (d_rsp_valid),
      .d_rsp_data  (d_rsp_data),
      .d_rsp_err   (d_rsp_err),
      .mem_en      (mem_en),
      .mem_we      (mem_we),
      .mem_be      (mem_be),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to the drive point of the next cycle.
   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      i_valid   = 1'b0;
      i_addr    = 32'h0;
      d_valid   = 1'b0;
      d_we      = 1'b0;
      d_be      = 4'h0;
      d_addr    = 32'h0;
      d_wdata   = 32'h0;
      mem_rdata = 32'h0;
   endtask

   task automatic do_reset();
      next_cycle();
      rst_n = 1'b0;
      idle_inputs();
      next_cycle();
      rst_n = 1'b1;
   endtask

   logic [31:0] exp_d;
   logic        prev_i;
   logic [31:0] prev_rd;

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      rst_n   = 1'b0;
      idle_inputs();

      // During reset with both valids high: nothing may be accepted.
      next_cycle();
      i_valid = 1'b1;
      d_valid = 1'b1;
      i_addr  = 32'h4;
      d_addr  = 32'h8;
      #1;
      check("rst_i_ready", {31'b0, i_ready}, 32'h0);
      check("rst_d_ready", {31'b0, d_ready}, 32'h0);
      check("rst_mem_en",  {31'b0, mem_en},  32'h0);
      check("rst_mem_we",  {31'b0, mem_we},  32'h0);
      next_cycle();
      #1;
      check("rst_i_rsp_valid", {31'b0, i_rsp_valid}, 32'h0);
      check("rst_d_rsp_valid", {31'b0, d_rsp_valid}, 32'h0);

      // First cycle after reset, idle.
      next_cycle();
      rst_n = 1'b1;
      idle_inputs();
      #1;
      check("post_rst_i_rsp_valid", {31'b0, i_rsp_valid}, 32'h0);
      check("post_rst_d_rsp_valid", {31'b0, d_rsp_valid}, 32'h0);
      check("post_rst_i_rsp_data",  i_rsp_data, 32'h0);
      check("post_rst_d_rsp_err",   {31'b0, d_rsp_err}, 32'h0);
      check("idle_mem_en",          {31'b0, mem_en}, 32'h0);
      check("idle_i_ready",         {31'b0, i_ready}, 32'h0);

      // Single fetch, i_addr 0x8 -> word 2.
      next_cycle();
      i_valid = 1'b1;
      i_addr  = 32'h8;
      #1;
      check("f_i_ready",  {31'b0, i_ready}, 32'h1);
      check("f_d_ready",  {31'b0, d_ready}, 32'h0);
      check("f_mem_en",   {31'b0, mem_en},  32'h1);
      check("f_mem_we",   {31'b0, mem_we},  32'h0);
      check("f_mem_be",   {28'b0, mem_be},  32'h0);
      check("f_mem_addr", 32'(mem_addr),    32'h2);
      next_cycle();
      i_valid   = 1'b0;
      mem_rdata = 32'hDEADBEEF;
      #1;
      check("f_rsp_valid",   {31'b0, i_rsp_valid}, 32'h1);
      check("f_rsp_data",    i_rsp_data, 32'hDEADBEEF);
      check("f_rsp_err",     {31'b0, i_rsp_err}, 32'h0);
      check("f_d_rsp_valid", {31'b0, d_rsp_valid}, 32'h0);
      check("f_d_rsp_data",  d_rsp_data, 32'h0);
      next_cycle();
      idle_inputs();
      #1;
      check("f_rsp_one_shot", {31'b0, i_rsp_valid}, 32'h0);

      // Conflict right after reset: grants I, D, I, D, one response per cycle.
      do_reset();
      prev_i  = 1'b0;
      prev_rd = 32'h0;
      for (int k = 0; k < 5; k++) begin
         if (k < 4) begin
            i_valid = 1'b1;
            d_valid = 1'b1;
            d_we    = 1'b0;
            i_addr  = 32'(4 * k);
            d_addr  = 32'(4 * (k + 10));
         end else begin
            i_valid = 1'b0;
            d_valid = 1'b0;
         end
         mem_rdata = 32'hA000_0000 + 32'(k);
         #1;
         if (k < 4) begin
            check("rr_i_ready", {31'b0, i_ready}, (k % 2 == 0) ? 32'h1 : 32'h0);
            check("rr_d_ready", {31'b0, d_ready}, (k % 2 == 0) ? 32'h0 : 32'h1);
            check("rr_mem_addr", 32'(mem_addr), (k % 2 == 0) ? 32'(k) : 32'(k + 10));
         end
         if (k > 0) begin
            check("rr_i_rsp_valid", {31'b0, i_rsp_valid}, {31'b0, prev_i});
            check("rr_d_rsp_valid", {31'b0, d_rsp_valid}, {31'b0, !prev_i});
            exp_d = prev_i ? 32'h0 : mem_rdata;
            check("rr_i_rsp_data", i_rsp_data, prev_i ? mem_rdata : 32'h0);
            check("rr_d_rsp_data", d_rsp_data, exp_d);
         end
         prev_i  = (k % 2 == 0);
         prev_rd = mem_rdata;
         next_cycle();
      end
      idle_inputs();

      // Data write: addr 0x10 -> word 4.
      d_valid = 1'b1;
      d_we    = 1'b1;
      d_be    = 4'hF;
      d_addr  = 32'h10;
      d_wdata = 32'h12345678;
      #1;
      check("w_d_ready",   {31'b0, d_ready}, 32'h1);
      check("w_mem_en",    {31'b0, mem_en},  32'h1);
      check("w_mem_we",    {31'b0, mem_we},  32'h1);
      check("w_mem_addr",  32'(mem_addr),    32'h4);
      check("w_mem_be",    {28'b0, mem_be},  32'hF);
      check("w_mem_wdata", mem_wdata, 32'h12345678);
      next_cycle();
      idle_inputs();
      mem_rdata = 32'hFFFF_FFFF;
      #1;
      check("w_rsp_valid", {31'b0, d_rsp_valid}, 32'h1);
      check("w_rsp_data",  d_rsp_data, 32'h0);
      check("w_rsp_err",   {31'b0, d_rsp_err}, 32'h0);

      // Misaligned data read.
      next_cycle();
      d_valid = 1'b1;
      d_addr  = 32'h102;
      #1;
      check("mis_d_ready", {31'b0, d_ready}, 32'h1);
      check("mis_mem_en",  {31'b0, mem_en},  32'h0);
      check("mis_mem_we",  {31'b0, mem_we},  32'h0);
      next_cycle();
      idle_inputs();
      mem_rdata = 32'h5555_AAAA;
      i_valid   = 1'b1;
      i_addr    = 32'(WORDS * 4);
      #1;
      check("mis_rsp_valid", {31'b0, d_rsp_valid}, 32'h1);
      check("mis_rsp_err",   {31'b0, d_rsp_err}, 32'h1);
      check("mis_rsp_data",  d_rsp_data, 32'h0);
      // Out-of-range fetch, pipelined behind the misaligned response.
      check("rng_i_ready", {31'b0, i_ready}, 32'h1);
      check("rng_mem_en",  {31'b0, mem_en},  32'h0);
      next_cycle();
      idle_inputs();
      mem_rdata = 32'h5555_AAAA;
      #1;
      check("rng_rsp_valid", {31'b0, i_rsp_valid}, 32'h1);
      check("rng_rsp_err",   {31'b0, i_rsp_err}, 32'h1);
      check("rng_rsp_data",  i_rsp_data, 32'h0);
      check("rng_d_rsp_valid", {31'b0, d_rsp_valid}, 32'h0);

      // Make D the last grant, then a fetch is reset mid-response.
      next_cycle();
      d_valid = 1'b1;
      d_addr  = 32'h0;
      next_cycle();
      idle_inputs();
      i_valid = 1'b1;
      i_addr  = 32'h0;
      #1;
      check("rr2_i_ready", {31'b0, i_ready}, 32'h1);
      next_cycle();
      rst_n = 1'b0;
      idle_inputs();
      #1;
      check("rstmid_i_rsp_valid", {31'b0, i_rsp_valid}, 32'h0);
      next_cycle();
      rst_n = 1'b1;
      #1;
      check("rstpost_i_rsp_valid", {31'b0, i_rsp_valid}, 32'h0);
      check("rstpost_d_rsp_valid", {31'b0, d_rsp_valid}, 32'h0);
      next_cycle();
      i_valid = 1'b1;
      d_valid = 1'b1;
      i_addr  = 32'h4;
      d_addr  = 32'h8;
      #1;
      check("rstpost_i_wins", {31'b0, i_ready}, 32'h1);
      check("rstpost_d_loses", {31'b0, d_ready}, 32'h0);
      next_cycle();
      idle_inputs();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
